// File: rtl/mask_unit_xbar_pkg.sv
// Shared types and the round-robin picker for the mask-unit lane read crossbar.
// Holds no logic or state of its own.
package mask_unit_xbar_pkg;

    localparam int NUM_LANES = 4;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 2;
    localparam int LANE_W    = 2;
    localparam int OFF_W     = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  writeIndex;
        logic [OFF_W-1:0]  dataOffset;
    } lane_resp_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OFF_W-1:0]  dataOffset;
        logic [LANE_W-1:0] readLane;
    } req_resp_t;

    // One-hot grant of the first set bit in mask, searching upward from ptr with wrap.
    function automatic logic [NUM_LANES-1:0] rr_pick(input logic [NUM_LANES-1:0] mask,
                                                     input logic [LANE_W-1:0]    ptr);
        logic [NUM_LANES-1:0] grant;
        logic                 found;
        logic [LANE_W-1:0]    idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = ptr + LANE_W'(k);
            if (!found && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mask_unit_resp_queue.sv
// One requester's response FIFO: 1-cycle push-to-head latency, no bypass.
// The caller must not push when full or pop when empty; count is registered.
module mask_unit_resp_queue
    import mask_unit_xbar_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pushEn,
    input  req_resp_t        pushEntry,
    input  logic             popEn,
    output req_resp_t        head,
    output logic [CNT_W-1:0] count
);

    req_resp_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    assign head = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem   <= '{default: '0};
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) begin
                mem[wrPtr] <= pushEntry;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(pushEn) - CNT_W'(popEn);
            assert (count <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/mask_unit_read_response_crossbar.sv
// Routes lane read responses back to requester writeIndex with per-requester round-robin and FIFOs.
// Lane handshake to resp_valid is 1 cycle; lane ready depends only on valid/writeIndex/count, never on resp_ready.
module mask_unit_read_response_crossbar
    import mask_unit_xbar_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lane_0_valid,
    output logic              lane_0_ready,
    input  logic [DATA_W-1:0] lane_0_bits_data,
    input  logic [IDX_W-1:0]  lane_0_bits_writeIndex,
    input  logic [OFF_W-1:0]  lane_0_bits_dataOffset,
    input  logic              lane_1_valid,
    output logic              lane_1_ready,
    input  logic [DATA_W-1:0] lane_1_bits_data,
    input  logic [IDX_W-1:0]  lane_1_bits_writeIndex,
    input  logic [OFF_W-1:0]  lane_1_bits_dataOffset,
    input  logic              lane_2_valid,
    output logic              lane_2_ready,
    input  logic [DATA_W-1:0] lane_2_bits_data,
    input  logic [IDX_W-1:0]  lane_2_bits_writeIndex,
    input  logic [OFF_W-1:0]  lane_2_bits_dataOffset,
    input  logic              lane_3_valid,
    output logic              lane_3_ready,
    input  logic [DATA_W-1:0] lane_3_bits_data,
    input  logic [IDX_W-1:0]  lane_3_bits_writeIndex,
    input  logic [OFF_W-1:0]  lane_3_bits_dataOffset,
    output logic              resp_0_valid,
    input  logic              resp_0_ready,
    output logic [DATA_W-1:0] resp_0_bits_data,
    output logic [OFF_W-1:0]  resp_0_bits_dataOffset,
    output logic [LANE_W-1:0] resp_0_bits_readLane,
    output logic              resp_1_valid,
    input  logic              resp_1_ready,
    output logic [DATA_W-1:0] resp_1_bits_data,
    output logic [OFF_W-1:0]  resp_1_bits_dataOffset,
    output logic [LANE_W-1:0] resp_1_bits_readLane,
    output logic              resp_2_valid,
    input  logic              resp_2_ready,
    output logic [DATA_W-1:0] resp_2_bits_data,
    output logic [OFF_W-1:0]  resp_2_bits_dataOffset,
    output logic [LANE_W-1:0] resp_2_bits_readLane,
    output logic              resp_3_valid,
    input  logic              resp_3_ready,
    output logic [DATA_W-1:0] resp_3_bits_data,
    output logic [OFF_W-1:0]  resp_3_bits_dataOffset,
    output logic [LANE_W-1:0] resp_3_bits_readLane
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    lane_resp_t                                laneIn [NUM_LANES];
    logic [NUM_LANES-1:0]                      laneValid;
    logic [NUM_LANES-1:0]                      laneReady;
    logic [NUM_REQ-1:0]                        respReady;
    logic [NUM_REQ-1:0]                        respValid;
    logic [NUM_REQ-1:0][NUM_LANES-1:0]         cand;
    logic [NUM_REQ-1:0][NUM_LANES-1:0]         grant;
    logic [NUM_REQ-1:0][LANE_W-1:0]            pushLane;
    logic [NUM_REQ-1:0][LANE_W-1:0]            rrPtr;
    logic [NUM_REQ-1:0]                        hasRoom;
    logic [NUM_REQ-1:0]                        pushEn;
    logic [NUM_REQ-1:0]                        popEn;
    req_resp_t                                 pushEntry [NUM_REQ];
    req_resp_t                                 head [NUM_REQ];
    logic [CNT_W-1:0]                          count [NUM_REQ];

    assign laneIn[0] = '{data: lane_0_bits_data, writeIndex: lane_0_bits_writeIndex, dataOffset: lane_0_bits_dataOffset};
    assign laneIn[1] = '{data: lane_1_bits_data, writeIndex: lane_1_bits_writeIndex, dataOffset: lane_1_bits_dataOffset};
    assign laneIn[2] = '{data: lane_2_bits_data, writeIndex: lane_2_bits_writeIndex, dataOffset: lane_2_bits_dataOffset};
    assign laneIn[3] = '{data: lane_3_bits_data, writeIndex: lane_3_bits_writeIndex, dataOffset: lane_3_bits_dataOffset};
    assign laneValid = {lane_3_valid, lane_2_valid, lane_1_valid, lane_0_valid};
    assign respReady = {resp_3_ready, resp_2_ready, resp_1_ready, resp_0_ready};

    always_comb begin
        cand     = '0;
        grant    = '0;
        pushLane = '0;
        hasRoom  = '0;
        pushEn   = '0;
        popEn    = '0;
        respValid = '0;
        laneReady = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            pushEntry[j] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cand[j][i] = laneValid[i] && (laneIn[i].writeIndex == IDX_W'(j));
            end
            grant[j]   = rr_pick(cand[j], rrPtr[j]);
            // Fullness uses the registered count only, so a pop never frees a slot in the same cycle.
            hasRoom[j] = count[j] < CNT_W'(DEPTH);
            pushEn[j]  = (grant[j] != '0) && hasRoom[j] && reset;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (grant[j][i]) begin
                    pushLane[j] = LANE_W'(i);
                end
            end
            pushEntry[j] = '{data:       laneIn[pushLane[j]].data,
                             dataOffset: laneIn[pushLane[j]].dataOffset,
                             readLane:   pushLane[j]};
            respValid[j] = count[j] != '0;
            popEn[j]     = respValid[j] && respReady[j];
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            laneReady[i] = grant[laneIn[i].writeIndex][i] && hasRoom[laneIn[i].writeIndex] && reset;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rrPtr <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (pushEn[j]) begin
                    rrPtr[j] <= pushLane[j] + LANE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (laneReady == '0);
        end
    end

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_queue
        mask_unit_resp_queue #(.DEPTH(DEPTH)) u_queue (
            .clock     (clock),
            .reset     (reset),
            .pushEn    (pushEn[j]),
            .pushEntry (pushEntry[j]),
            .popEn     (popEn[j]),
            .head      (head[j]),
            .count     (count[j])
        );
    end

    assign lane_0_ready = laneReady[0];
    assign lane_1_ready = laneReady[1];
    assign lane_2_ready = laneReady[2];
    assign lane_3_ready = laneReady[3];

    assign resp_0_valid           = respValid[0];
    assign resp_0_bits_data       = head[0].data;
    assign resp_0_bits_dataOffset = head[0].dataOffset;
    assign resp_0_bits_readLane   = head[0].readLane;
    assign resp_1_valid           = respValid[1];
    assign resp_1_bits_data       = head[1].data;
    assign resp_1_bits_dataOffset = head[1].dataOffset;
    assign resp_1_bits_readLane   = head[1].readLane;
    assign resp_2_valid           = respValid[2];
    assign resp_2_bits_data       = head[2].data;
    assign resp_2_bits_dataOffset = head[2].dataOffset;
    assign resp_2_bits_readLane   = head[2].readLane;
    assign resp_3_valid           = respValid[3];
    assign resp_3_bits_data       = head[3].data;
    assign resp_3_bits_dataOffset = head[3].dataOffset;
    assign resp_3_bits_readLane   = head[3].readLane;

endmodule

// File: tb/tb_mask_unit_read_response_crossbar.sv
// Scoreboard bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_mask_unit_read_response_crossbar;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic [1:0]  lane;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  lv, lrdy, rvld, rrdy;
    logic [1:0]  lwi [4];
    logic [1:0]  loff [4];
    logic [31:0] ldat [4];
    logic [31:0] rdat [4];
    logic [1:0]  roff [4];
    logic [1:0]  rlane [4];

    logic [3:0]  nv, nrr;
    logic [1:0]  nwi [4];
    logic [1:0]  noff [4];
    logic [31:0] ndat [4];

    ent_t expQ [4][$];
    int   modelCnt [4];
    int   rrM [4];
    int   nTests = 0;
    int   nFail = 0;
    bit   monOn = 1'b0;

    always #5 clock = ~clock;

    mask_unit_read_response_crossbar #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .lane_0_valid(lv[0]), .lane_0_ready(lrdy[0]), .lane_0_bits_data(ldat[0]),
        .lane_0_bits_writeIndex(lwi[0]), .lane_0_bits_dataOffset(loff[0]),
        .lane_1_valid(lv[1]), .lane_1_ready(lrdy[1]), .lane_1_bits_data(ldat[1]),
        .lane_1_bits_writeIndex(lwi[1]), .lane_1_bits_dataOffset(loff[1]),
        .lane_2_valid(lv[2]), .lane_2_ready(lrdy[2]), .lane_2_bits_data(ldat[2]),
        .lane_2_bits_writeIndex(lwi[2]), .lane_2_bits_dataOffset(loff[2]),
        .lane_3_valid(lv[3]), .lane_3_ready(lrdy[3]), .lane_3_bits_data(ldat[3]),
        .lane_3_bits_writeIndex(lwi[3]), .lane_3_bits_dataOffset(loff[3]),
        .resp_0_valid(rvld[0]), .resp_0_ready(rrdy[0]), .resp_0_bits_data(rdat[0]),
        .resp_0_bits_dataOffset(roff[0]), .resp_0_bits_readLane(rlane[0]),
        .resp_1_valid(rvld[1]), .resp_1_ready(rrdy[1]), .resp_1_bits_data(rdat[1]),
        .resp_1_bits_dataOffset(roff[1]), .resp_1_bits_readLane(rlane[1]),
        .resp_2_valid(rvld[2]), .resp_2_ready(rrdy[2]), .resp_2_bits_data(rdat[2]),
        .resp_2_bits_dataOffset(roff[2]), .resp_2_bits_readLane(rlane[2]),
        .resp_3_valid(rvld[3]), .resp_3_ready(rrdy[3]), .resp_3_bits_data(rdat[3]),
        .resp_3_bits_dataOffset(roff[3]), .resp_3_bits_readLane(rlane[3])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stage lane/requester inputs; data and offsets are random.
    task automatic stage(input logic [3:0] v, input logic [7:0] wi, input logic [3:0] rr);
        nv  = v;
        nrr = rr;
        for (int i = 0; i < 4; i++) begin
            nwi[i]  = wi[2*i +: 2];
            ndat[i] = $urandom;
            noff[i] = 2'($urandom_range(0, 3));
        end
    endtask

    // Apply staged inputs for one cycle; the model decides grants and fills the scoreboard.
    task automatic step();
        logic [3:0] expRdy;
        @(negedge clock);
        reset = 1'b1;
        lv    = nv;
        rrdy  = nrr;
        for (int i = 0; i < 4; i++) begin
            lwi[i]  = nwi[i];
            ldat[i] = ndat[i];
            loff[i] = noff[i];
        end
        #2;
        expRdy = '0;
        for (int j = 0; j < 4; j++) begin
            int win;
            bit popping;
            win = -1;
            for (int k = 0; k < 4; k++) begin
                int l;
                l = (rrM[j] + k) % 4;
                if (win < 0 && nv[l] && nwi[l] == 2'(j)) win = l;
            end
            popping = (modelCnt[j] > 0) && nrr[j];
            if (win >= 0 && modelCnt[j] < DEPTH) begin
                expRdy[win] = 1'b1;
                expQ[j].push_back('{ndat[win], noff[win], 2'(win)});
                rrM[j] = (win + 1) % 4;
                modelCnt[j]++;
            end
            if (popping) modelCnt[j]--;
        end
        check("lane_ready", {60'd0, lrdy}, {60'd0, expRdy});
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            reset = 1'b0;
            lv    = 4'hF;
            rrdy  = 4'h0;
            for (int i = 0; i < 4; i++) lwi[i] = 2'($urandom_range(0, 3));
            #2;
            check("ready_in_reset", {60'd0, lrdy}, 64'd0);
        end
        for (int j = 0; j < 4; j++) begin
            expQ[j].delete();
            modelCnt[j] = 0;
            rrM[j]      = 0;
        end
    endtask

    // Monitor: pops and compares whenever a requester handshake is presented.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            #1;
            if (monOn) begin
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("resp%0d_valid", j), {63'd0, rvld[j]}, {63'd0, expQ[j].size() != 0});
                    if (rvld[j] === 1'b1 && rrdy[j] === 1'b1 && expQ[j].size() != 0) begin
                        e = expQ[j].pop_front();
                        check($sformatf("resp%0d_data", j), {32'd0, rdat[j]}, {32'd0, e.data});
                        check($sformatf("resp%0d_off", j), {62'd0, roff[j]}, {62'd0, e.off});
                        check($sformatf("resp%0d_lane", j), {62'd0, rlane[j]}, {62'd0, e.lane});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        lv   = '0;
        rrdy = '0;
        for (int i = 0; i < 4; i++) begin
            lwi[i] = '0; ldat[i] = '0; loff[i] = '0;
        end
        do_reset(2);
        monOn = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("reset_data", {32'd0, rdat[j]}, 64'd0);
            check("reset_lane", {62'd0, rlane[j]}, 64'd0);
        end

        // single response lane 2 -> requester 1
        stage(4'b0100, 8'b00_01_00_00, 4'b0000);
        ndat[2] = 32'hDEADBEEF;
        noff[2] = 2'd3;
        step();
        stage(4'b0000, 8'h00, 4'b0000);
        step();
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // contention: all lanes to requester 0
        repeat (4) begin
            stage(4'hF, 8'h00, 4'b0001);
            step();
        end
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // full/backpressure on requester 2, lane 0 to requester 3 independent
        repeat (4) begin
            stage(4'b1011, {2'd2, 2'd0, 2'd2, 2'd3}, 4'b1000);
            step();
        end
        repeat (4) begin
            stage(4'b1011, {2'd2, 2'd0, 2'd2, 2'd3}, 4'b1100);
            step();
        end
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // concurrent push/pop on requester 0 across pointer wrap
        stage(4'b0001, 8'h00, 4'b0000);
        step();
        repeat (8) begin
            stage(4'(1 << $urandom_range(0, 3)), 8'h00, 4'b0001);
            step();
        end
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // parallel routing lanes 0..3 -> requesters 3..0
        stage(4'hF, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000);
        step();
        stage(4'b0000, 8'h00, 4'b0000);
        step();
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // reset mid-operation with requester 1 full
        stage(4'b0011, 8'b00_00_01_01, 4'b0000);
        repeat (2) step();
        do_reset(1);
        stage(4'hF, 8'h00, 4'hF);
        step();
        check("post_reset_winner", {60'd0, lrdy}, 64'd1);
        stage(4'b0000, 8'h00, 4'hF);
        repeat (3) step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end
            stage(4'($urandom), 8'($urandom), 4'($urandom | $urandom));
            step();
        end

        stage(4'b0000, 8'h00, 4'hF);
        repeat (6) step();
        total = 0;
        for (int j = 0; j < 4; j++) total += expQ[j].size();
        check("drain_empty", 64'(total), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
